// File: rtl/counter_ctrl_pkg.sv
// rtl/counter_ctrl_pkg.sv - shared state type and seek-planning helper for the counter seek sequencer
package counter_ctrl_pkg;

    localparam int CNT_WIDTH = 4;
    localparam logic [CNT_WIDTH-1:0] HALF = CNT_WIDTH'(2**(CNT_WIDTH-1));

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEEK  = 2'd1,
        ZERO  = 2'd2,
        CHECK = 2'd3
    } seek_state_t;

    // Shortest modular path: returns {dir, dist}, dir=1 means count up; a half-turn tie goes up.
    function automatic logic [CNT_WIDTH:0] seek_plan(input logic [CNT_WIDTH-1:0] count,
                                                     input logic [CNT_WIDTH-1:0] target);
        logic [CNT_WIDTH-1:0] d;
        d = target - count;
        if (d <= HALF) return {1'b1, d};
        else           return {1'b0, CNT_WIDTH'(-d)};
    endfunction

endpackage

// File: rtl/counter_seek_dir.sv
// rtl/counter_seek_dir.sv - combinational seek direction/distance; COUNTER_SEEK_NO_WRAP_EN forbids crossing the wrap boundary
module counter_seek_dir
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) (
    input  logic [WIDTH-1:0] count_in,
    input  logic [WIDTH-1:0] cmd_target,
    output logic             o_dir,
    output logic [WIDTH-1:0] o_dist
);

`ifdef COUNTER_SEEK_NO_WRAP_EN
    always_comb begin
        o_dir  = 1'b0;
        o_dist = count_in - cmd_target;
        if (cmd_target > count_in) begin
            o_dir  = 1'b1;
            o_dist = cmd_target - count_in;
        end
    end
`else
    localparam logic [WIDTH-1:0] W_HALF = WIDTH'(2**(WIDTH-1));
    logic [WIDTH-1:0] w_diff;

    assign w_diff = cmd_target - count_in;

    always_comb begin
        o_dir  = 1'b1;
        o_dist = w_diff;
        if (w_diff > W_HALF) begin
            o_dir  = 1'b0;
            o_dist = WIDTH'(-w_diff);
        end
    end
`endif

endmodule

// File: rtl/counter_seek_ctrl.sv
// rtl/counter_seek_ctrl.sv - seek/zero sequencer driving one up/down counter; COUNTER_SEEK_NO_WRAP_EN selects non-wrapping seeks
module counter_seek_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_zero,
    input  logic [WIDTH-1:0] cmd_target,
    input  logic [WIDTH-1:0] count_in,
    output logic             cnt_enable,
    output logic             cnt_up_down,
    output logic             cnt_rst,
    output logic             busy,
    output logic             done,
    output logic             err
);

    seek_state_t      r_state;
    logic [WIDTH-1:0] r_target;
    logic [WIDTH-1:0] r_dist;
    logic             r_dir;
    logic             r_cnt_enable;
    logic             r_cnt_up_down;
    logic             r_cnt_rst;
    logic             r_busy;
    logic             r_done;
    logic             w_dir;
    logic [WIDTH-1:0] w_dist;

    counter_seek_dir #(.WIDTH(WIDTH)) u_dir (
        .count_in   (count_in),
        .cmd_target (cmd_target),
        .o_dir      (w_dir),
        .o_dist     (w_dist)
    );

    assign cmd_ready = (r_state == IDLE) && !rst;

    // Outputs are registered alongside the state they belong to, so each flop matches the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_target      <= '0;
            r_dist        <= '0;
            r_dir         <= 1'b0;
            r_cnt_enable  <= 1'b0;
            r_cnt_up_down <= 1'b1;
            r_cnt_rst     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_cnt_enable  <= 1'b0;
            r_cnt_up_down <= 1'b1;
            r_cnt_rst     <= 1'b0;
            r_done        <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        r_busy <= 1'b1;
                        if (cmd_zero) begin
                            r_target  <= '0;
                            r_cnt_rst <= 1'b1;
                            r_state   <= ZERO;
                        end else begin
                            r_target <= cmd_target;
                            r_dist   <= w_dist;
                            r_dir    <= w_dir;
                            if (w_dist == '0) begin
                                r_done  <= 1'b1;
                                r_state <= CHECK;
                            end else begin
                                r_cnt_enable  <= 1'b1;
                                r_cnt_up_down <= w_dir;
                                r_state       <= SEEK;
                            end
                        end
                    end
                end
                SEEK: begin
                    r_dist <= r_dist - WIDTH'(1);
                    if (r_dist == WIDTH'(1)) begin
                        r_done  <= 1'b1;
                        r_state <= CHECK;
                    end else begin
                        r_cnt_enable  <= 1'b1;
                        r_cnt_up_down <= r_dir;
                    end
                end
                ZERO: begin
                    r_done  <= 1'b1;
                    r_state <= CHECK;
                end
                CHECK: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cnt_enable  = r_cnt_enable;
    assign cnt_up_down = r_cnt_up_down;
    assign cnt_rst     = r_cnt_rst;
    assign busy        = r_busy;
    assign done        = r_done;
    // The counter's last edge lands at CHECK entry, so the compare must use the live count.
    assign err         = r_done && (count_in != r_target);

endmodule
